// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared memType encodings, data memory depth default and lane helpers
package mem_stage_pkg;
  localparam int DM_WORDS_DEFAULT = 4096;
  typedef enum logic [2:0] {
    MT_WORD   = 3'b000,
    MT_HALF_S = 3'b001,
    MT_HALF_U = 3'b010,
    MT_BYTE_S = 3'b011,
    MT_BYTE_U = 3'b100
  } mem_type_e;
  function automatic logic is_half(input logic [2:0] mt);
    return mt == MT_HALF_S || mt == MT_HALF_U;
  endfunction
  function automatic logic is_byte(input logic [2:0] mt);
    return mt == MT_BYTE_S || mt == MT_BYTE_U;
  endfunction
  function automatic logic [3:0] lane_en(input logic [2:0] mt, input logic [1:0] a);
    return is_half(mt) ? (a[1] ? 4'b1100 : 4'b0011) : is_byte(mt) ? 4'b0001 << a : 4'b1111;
  endfunction
  // store data replicated into every lane so the enabled lanes pick it up in place
  function automatic logic [31:0] lane_data(input logic [2:0] mt, input logic [31:0] d);
    return is_half(mt) ? {2{d[15:0]}} : is_byte(mt) ? {4{d[7:0]}} : d;
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: E-stage inputs, hazard-unit forward controls and M-stage outputs of the memory stage
//   master: Execute/hazard side (drives *_E_i, WD_Msel, W_forward; reads M outputs)
//   slave : mem_stage
interface mem_stage_if;
  logic [31:0] result_E_i;
  logic [31:0] RD2_E_i;
  logic [31:0] PC_E_i;
  logic [31:0] PCn_E_i;
  logic [4:0]  A2_E_i;
  logic [4:0]  A3_E_i;
  logic        regWrite_E_i;
  logic        memWrite_E_i;
  logic [2:0]  memType_E_i;
  logic [31:0] OP_E_i;
  logic        WD_Msel;
  logic [31:0] W_forward;
  logic [31:0] M_result;
  logic [31:0] RD_M_o;
  logic [31:0] PCn_M_o;
  logic [4:0]  A2_M_o;
  logic [4:0]  A3_M_o;
  logic        regWrite_M_o;
  logic [31:0] OP_M_o;
  modport master (
    output result_E_i, RD2_E_i, PC_E_i, PCn_E_i, A2_E_i, A3_E_i, regWrite_E_i,
           memWrite_E_i, memType_E_i, OP_E_i, WD_Msel, W_forward,
    input  M_result, RD_M_o, PCn_M_o, A2_M_o, A3_M_o, regWrite_M_o, OP_M_o
  );
  modport slave (
    input  result_E_i, RD2_E_i, PC_E_i, PCn_E_i, A2_E_i, A3_E_i, regWrite_E_i,
           memWrite_E_i, memType_E_i, OP_E_i, WD_Msel, W_forward,
    output M_result, RD_M_o, PCn_M_o, A2_M_o, A3_M_o, regWrite_M_o, OP_M_o
  );
endinterface

// File: rtl/mem_stage_data_mem.sv
// data_mem: DM_WORDS x 32 data memory with lane-merged stores, async clear and optional store trace
//   clk, reset : clock, async active-high clear of the whole array
//   we         : store enable for the access in M
//   addr       : byte address; word index addr[AW+1:2], lanes addr[1:0]
//   wd         : effective store data (low 8/16 bits used for byte/half)
//   mem_type   : access type selecting the written lanes
//   pc         : M-stage PC, only present with DM_TRACE_EN for the store trace
//   rd         : current word at addr, 0 when addr is out of range
//   DM_TRACE_EN: when defined, each performed store prints "@pc: *addr <= word"
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic [2:0]  mem_type,
`ifdef DM_TRACE_EN
  input  logic [31:0] pc,
`endif
  output logic [31:0] rd
);
  localparam int AW = $clog2(DM_WORDS);
  logic [31:0] mem [DM_WORDS];
  logic [AW-1:0] idx;
  logic in_range;
  logic [3:0] be;
  logic [31:0] wdata, cur, merged;
  assign idx = addr[AW+1:2];
  assign in_range = addr < 32'(4 * DM_WORDS);
  assign be = lane_en(mem_type, addr[1:0]);
  assign wdata = lane_data(mem_type, wd);
  assign cur = mem[idx];
  assign rd = in_range ? cur : '0;
  always_comb begin
    merged = cur;
    for (int i = 0; i < 4; i++)
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
    else if (we && in_range) begin
      mem[idx] <= merged;
`ifdef DM_TRACE_EN
      $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged);
`endif
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage - E/M pipeline register, data memory access and load extension
//   clk, reset : pipeline clock, async active-high reset of register and memory
//   bus        : mem_stage_if.slave carrying the E-stage fields, WD_Msel/W_forward store-data
//                forward, and the M-stage outputs (M_result, RD_M_o, pass-through fields)
//   DM_TRACE_EN: enables the store trace inside data_mem
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEFAULT
) (
  input logic clk,
  input logic reset,
  mem_stage_if.slave bus
);
  logic [31:0] m_result, rd2_m, pcn_m, op_m, wd, word;
  logic [4:0] a2_m, a3_m;
  logic reg_write_m, mem_write_m;
  logic [2:0] mem_type_m;
  logic [7:0] b;
  logic [15:0] h;
`ifdef DM_TRACE_EN
  logic [31:0] pc_m;
  always_ff @(posedge clk or posedge reset)
    if (reset) pc_m <= '0;
    else pc_m <= bus.PC_E_i;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      m_result    <= '0;
      rd2_m       <= '0;
      pcn_m       <= '0;
      op_m        <= '0;
      a2_m        <= '0;
      a3_m        <= '0;
      reg_write_m <= 1'b0;
      mem_write_m <= 1'b0;
      mem_type_m  <= '0;
    end else begin
      m_result    <= bus.result_E_i;
      rd2_m       <= bus.RD2_E_i;
      pcn_m       <= bus.PCn_E_i;
      op_m        <= bus.OP_E_i;
      a2_m        <= bus.A2_E_i;
      a3_m        <= bus.A3_E_i;
      reg_write_m <= bus.regWrite_E_i;
      mem_write_m <= bus.memWrite_E_i;
      mem_type_m  <= bus.memType_E_i;
    end
  assign wd = bus.WD_Msel ? bus.W_forward : rd2_m;
  data_mem #(.DM_WORDS(DM_WORDS)) u_dm (
    .clk      (clk),
    .reset    (reset),
    .we       (mem_write_m),
    .addr     (m_result),
    .wd       (wd),
    .mem_type (mem_type_m),
`ifdef DM_TRACE_EN
    .pc       (pc_m),
`endif
    .rd       (word)
  );
  assign b = word[8*m_result[1:0] +: 8];
  assign h = m_result[1] ? word[31:16] : word[15:0];
  always_comb
    bus.RD_M_o = mem_type_m == MT_HALF_S ? {{16{h[15]}}, h} :
                 mem_type_m == MT_HALF_U ? {16'b0, h} :
                 mem_type_m == MT_BYTE_S ? {{24{b[7]}}, b} :
                 mem_type_m == MT_BYTE_U ? {24'b0, b} : word;
  assign bus.M_result     = m_result;
  assign bus.PCn_M_o      = pcn_m;
  assign bus.A2_M_o       = a2_m;
  assign bus.A3_M_o       = a3_m;
  assign bus.regWrite_M_o = reg_write_m;
  assign bus.OP_M_o       = op_m;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage
module tb_mem_stage;
  import mem_stage_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  mem_stage_if bus();
  mem_stage dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [2:0] mt);
    bus.result_E_i   = a;
    bus.RD2_E_i      = d;
    bus.memWrite_E_i = we;
    bus.memType_E_i  = mt;
    bus.PC_E_i       = 32'h0040_0000 + a;
    bus.PCn_E_i      = 32'h0040_0004 + a;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.result_E_i = 32'h10; bus.RD2_E_i = 32'h5; bus.PC_E_i = 32'h100; bus.PCn_E_i = 32'h104;
    bus.A2_E_i = 5'd3; bus.A3_E_i = 5'd4; bus.regWrite_E_i = 1'b1; bus.memWrite_E_i = 1'b1;
    bus.memType_E_i = MT_WORD; bus.OP_E_i = 32'hFFFF_FFFF; bus.WD_Msel = 1'b0; bus.W_forward = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.M_result !== 32'h0) begin errors++; $display("FAIL reset_M_result: got %h want 00000000", bus.M_result); end
    checks++; if (bus.RD_M_o !== 32'h0) begin errors++; $display("FAIL reset_RD_M_o: got %h want 00000000", bus.RD_M_o); end
    checks++; if ({bus.PCn_M_o, bus.OP_M_o} !== 64'h0) begin errors++; $display("FAIL reset_pcn_op: got %h want 0", {bus.PCn_M_o, bus.OP_M_o}); end
    checks++; if ({bus.A2_M_o, bus.A3_M_o, bus.regWrite_M_o} !== 11'h0) begin errors++; $display("FAIL reset_regs: got %h want 0", {bus.A2_M_o, bus.A3_M_o, bus.regWrite_M_o}); end
    @(negedge clk);
    reset = 1'b0;
    bus.memWrite_E_i = 1'b0;
  endtask

  task automatic test_word_store;
    bus.A2_E_i = 5'd7; bus.A3_E_i = 5'd9; bus.regWrite_E_i = 1'b1; bus.OP_E_i = 32'hAC09_0010;
    issue(32'h10, 32'h1234_5678, 1'b1, MT_WORD);
    checks++; if (bus.M_result !== 32'h10) begin errors++; $display("FAIL word_M_result: got %h want 00000010", bus.M_result); end
    checks++; if ({bus.A2_M_o, bus.A3_M_o, bus.regWrite_M_o} !== {5'd7, 5'd9, 1'b1}) begin errors++; $display("FAIL word_passthru_regs: got %h want %h", {bus.A2_M_o, bus.A3_M_o, bus.regWrite_M_o}, {5'd7, 5'd9, 1'b1}); end
    checks++; if (bus.OP_M_o !== 32'hAC09_0010 || bus.PCn_M_o !== 32'h0040_0014) begin errors++; $display("FAIL word_passthru_op_pcn: got %h %h want ac090010 00400014", bus.OP_M_o, bus.PCn_M_o); end
    checks++; if (bus.RD_M_o !== 32'h0) begin errors++; $display("FAIL word_before_write: got %h want 00000000", bus.RD_M_o); end
    bus.regWrite_E_i = 1'b0; bus.A2_E_i = 5'd0; bus.A3_E_i = 5'd0; bus.OP_E_i = 32'h0;
    issue(32'h10, 32'h0, 1'b0, MT_WORD);
    checks++; if (bus.RD_M_o !== 32'h1234_5678) begin errors++; $display("FAIL word_load: got %h want 12345678", bus.RD_M_o); end
  endtask

  task automatic test_byte;
    issue(32'h11, 32'h0000_00AB, 1'b1, MT_BYTE_U);
    issue(32'h10, 32'h0, 1'b0, MT_WORD);
    checks++; if (bus.RD_M_o !== 32'h1234_AB78) begin errors++; $display("FAIL byte_merge: got %h want 1234ab78", bus.RD_M_o); end
    issue(32'h11, 32'h0, 1'b0, MT_BYTE_S);
    checks++; if (bus.RD_M_o !== 32'hFFFF_FFAB) begin errors++; $display("FAIL byte_signed: got %h want ffffffab", bus.RD_M_o); end
    issue(32'h11, 32'h0, 1'b0, MT_BYTE_U);
    checks++; if (bus.RD_M_o !== 32'h0000_00AB) begin errors++; $display("FAIL byte_unsigned: got %h want 000000ab", bus.RD_M_o); end
    issue(32'h13, 32'h0, 1'b0, MT_BYTE_S);
    checks++; if (bus.RD_M_o !== 32'h0000_0012) begin errors++; $display("FAIL byte_lane3_signed: got %h want 00000012", bus.RD_M_o); end
  endtask

  task automatic test_half;
    issue(32'h12, 32'hFFFF_8001, 1'b1, MT_HALF_S);
    issue(32'h10, 32'h0, 1'b0, MT_WORD);
    checks++; if (bus.RD_M_o !== 32'h8001_AB78) begin errors++; $display("FAIL half_merge: got %h want 8001ab78", bus.RD_M_o); end
    issue(32'h12, 32'h0, 1'b0, MT_HALF_S);
    checks++; if (bus.RD_M_o !== 32'hFFFF_8001) begin errors++; $display("FAIL half_signed: got %h want ffff8001", bus.RD_M_o); end
    issue(32'h13, 32'h0, 1'b0, MT_HALF_U);
    checks++; if (bus.RD_M_o !== 32'h0000_8001) begin errors++; $display("FAIL half_unsigned_a0_ignored: got %h want 00008001", bus.RD_M_o); end
    issue(32'h10, 32'h0, 1'b0, MT_HALF_S);
    checks++; if (bus.RD_M_o !== 32'hFFFF_AB78) begin errors++; $display("FAIL half_low_signed: got %h want ffffab78", bus.RD_M_o); end
    issue(32'h13, 32'h0, 1'b0, 3'b111);
    checks++; if (bus.RD_M_o !== 32'h8001_AB78) begin errors++; $display("FAIL other_code_as_word: got %h want 8001ab78", bus.RD_M_o); end
  endtask

  task automatic test_forward;
    issue(32'h20, 32'h0000_0001, 1'b1, MT_WORD);
    bus.WD_Msel = 1'b1; bus.W_forward = 32'hDEAD_BEEF;
    issue(32'h24, 32'h0BAD_F00D, 1'b1, MT_WORD);
    bus.WD_Msel = 1'b0;
    issue(32'h20, 32'h0, 1'b0, MT_WORD);
    checks++; if (bus.RD_M_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fwd_store_data: got %h want deadbeef", bus.RD_M_o); end
    issue(32'h24, 32'h0, 1'b0, MT_WORD);
    checks++; if (bus.RD_M_o !== 32'h0BAD_F00D) begin errors++; $display("FAIL latched_store_data: got %h want 0badf00d", bus.RD_M_o); end
  endtask

  task automatic test_bounds;
    issue(32'h3FFC, 32'hCAFE_F00D, 1'b1, MT_WORD);
    issue(32'h4000, 32'hFFFF_FFFF, 1'b1, MT_WORD);
    checks++; if (bus.RD_M_o !== 32'h0) begin errors++; $display("FAIL oor_read: got %h want 00000000", bus.RD_M_o); end
    issue(32'h0, 32'h0, 1'b0, MT_WORD);
    checks++; if (bus.RD_M_o !== 32'h0) begin errors++; $display("FAIL oor_no_alias_word0: got %h want 00000000", bus.RD_M_o); end
    issue(32'h3FFC, 32'h0, 1'b0, MT_WORD);
    checks++; if (bus.RD_M_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL top_word: got %h want cafef00d", bus.RD_M_o); end
    issue(32'h10, 32'h0, 1'b0, MT_WORD);
    checks++; if (bus.RD_M_o !== 32'h8001_AB78) begin errors++; $display("FAIL oor_mem_unchanged: got %h want 8001ab78", bus.RD_M_o); end
  endtask

  task automatic test_async_reset;
    bus.regWrite_E_i = 1'b1; bus.A3_E_i = 5'd5; bus.OP_E_i = 32'h1234;
    issue(32'h10, 32'h5555_5555, 1'b1, MT_WORD);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.M_result !== 32'h0 || bus.RD_M_o !== 32'h0) begin errors++; $display("FAIL async_reset_outputs: got %h %h want 0 0", bus.M_result, bus.RD_M_o); end
    checks++; if ({bus.A3_M_o, bus.regWrite_M_o, bus.OP_M_o, bus.PCn_M_o} !== 70'h0) begin errors++; $display("FAIL async_reset_fields: got %h want 0", {bus.A3_M_o, bus.regWrite_M_o, bus.OP_M_o, bus.PCn_M_o}); end
    bus.regWrite_E_i = 1'b0; bus.A3_E_i = 5'd0; bus.OP_E_i = 32'h0;
    bus.memWrite_E_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    issue(32'h10, 32'h0, 1'b0, MT_WORD);
    checks++; if (bus.RD_M_o !== 32'h0) begin errors++; $display("FAIL reset_clears_0x10: got %h want 00000000", bus.RD_M_o); end
    issue(32'h3FFC, 32'h0, 1'b0, MT_WORD);
    checks++; if (bus.RD_M_o !== 32'h0) begin errors++; $display("FAIL reset_clears_0x3ffc: got %h want 00000000", bus.RD_M_o); end
  endtask

  initial begin
    test_reset;
    test_word_store;
    test_byte;
    test_half;
    test_forward;
    test_bounds;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
